multicycle_core: RTL and testbench
==================================

# multicycle_core

Multi-cycle RV32I subset core that executes ADD, SUB, ADDI, BEQ, BNE and EBREAK through a fetch/decode/execute/writeback state machine. It fetches over a variable-latency instruction-memory handshake with a watchdog timeout, and holds an internal 32x32 register file with x0 hardwired to zero. It replaces the single-cycle top for programs needing wait-stated memory and reports halt/fault status to the test harness.

## Interface
- ADDR_WIDTH, 32: PC / instruction address width; PC arithmetic wraps modulo 2^ADDR_WIDTH.
- RESET_PC, 0: PC value loaded on reset; must be 4-byte aligned.
- FETCH_TIMEOUT, 16: maximum wait cycles for imem_valid; 0 disables the watchdog.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, synchronous and active-high.
- imem_req  out  1  fetch request; held high for the whole FETCH state.
- imem_addr  out  ADDR_WIDTH  fetch address, equal to PC; stable while imem_req is high.
- imem_valid  in  1  instruction valid; sampled only while imem_req is high.
- imem_rdata  in  32  instruction word; captured on the edge where imem_valid=1.
- a0  out  32  continuous copy of register x10.
- retire  out  1  one-cycle pulse in the WRITEBACK cycle of each completed instruction.
- halted  out  1  high once the core is in HALT.
- fault  out  2  halt cause: 0 = EBREAK/none, 1 = illegal instruction, 2 = fetch timeout, 3 = misaligned branch target.

## Operation
- States: FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- Reset behaviour:
  - Any edge with rst=1 sets state=FETCH, PC=RESET_PC, all registers=0, instr=0 and wait counter=0.
  - Outputs after reset: imem_req=1, imem_addr=RESET_PC, a0=0, retire=0, halted=0, fault=0.
  - rst overrides every state, including mid-fetch and HALT.
- FETCH:
  - imem_req=1.
  - imem_valid=1 on an edge: latch imem_rdata into instr, clear the counter, go to DECODE.
  - Otherwise the counter increments.
  - FETCH_TIMEOUT≠0 and counter reaches FETCH_TIMEOUT with no valid: go to HALT, fault=2.
- DECODE:
  - Latch rs1/rs2 register values and the immediate.
  - I-immediate is instr[31:20], sign-extended.
  - B-immediate is {instr[31],instr[7],instr[30:25],instr[11:8],0}, sign-extended.
  - Unsupported encodings go to HALT with fault=1.
  - Supported encodings:
    - ADD: opcode 0110011, funct3 000, funct7 0000000.
    - SUB: opcode 0110011, funct3 000, funct7 0100000.
    - ADDI: opcode 0010011, funct3 000.
    - BEQ: opcode 1100011, funct3 000.
    - BNE: opcode 1100011, funct3 001.
    - EBREAK: 32'h00100073.
  - EBREAK goes to HALT with fault=0 and no retire.
- EXECUTE:
  - ALU result is a 32-bit add/sub, truncated (overflow ignored).
  - Branches: compute EQ; target = PC + B-imm, wrapped.
  - Taken branch with target[1]=1: go to HALT, fault=3.
- WRITEBACK:
  - ALU ops write rd when rd≠0; writes to x0 are discarded.
  - PC ← target if the branch is taken, else PC+4.
  - retire=1 for this cycle only; next state is FETCH.
- HALT:
  - Terminal until rst.
  - imem_req=0, halted=1; fault is held.
  - Register file and a0 frozen.
- imem_valid outside FETCH is ignored. The memory is reset by the same rst, and no response from a request issued before reset may be delivered after it.

## Timing
- Minimum 4 cycles per instruction: FETCH (valid in its first cycle), DECODE, EXECUTE, WRITEBACK.
- Each memory wait cycle adds one cycle.
- Register write and PC update take effect at the end of WRITEBACK.
  - a0 reflects the new x10 in the first cycle of the following FETCH.
- imem_req rises in the first FETCH cycle.
  - After reset deassertion: the first cycle with rst=0 is a FETCH cycle with req=1.
  - imem_req falls on the edge that accepts valid.
- Timeout: with FETCH_TIMEOUT=N, fault=2 and halted=1 appear on the edge ending the Nth consecutive FETCH cycle without valid.
  - Valid arriving in that same cycle wins; no fault.
- Faults and EBREAK are detected in DECODE/EXECUTE. halted rises on the following edge, and retire is never asserted for the faulting instruction.
- Read-after-write is safe because of the strict sequencing; no forwarding is required.

## Test plan
- Zero-wait program (`addi x10,x0,5; addi x10,x10,-7; ebreak`) at RESET_PC=0:
  - Expect retire pulses at cycles 4 and 8.
  - Expect a0=0xFFFFFFFE.
  - Expect halted=1, fault=0 after the EBREAK decode.
- Memory with 3 wait cycles per fetch, FETCH_TIMEOUT=16, `add x10,x1,x2` with x1=x2=0:
  - Expect 7 cycles per instruction.
  - Expect imem_addr stable across the waits.
- Loop `addi x5,x0,3; addi x5,x5,-1; bne x5,x0,-4; addi x10,x0,1; ebreak`:
  - Expect exactly 3 BNE retires (two taken, back to 0x4).
  - Expect final a0=1.
- Stall imem_valid, FETCH_TIMEOUT=4:
  - Expect halted=1, fault=2 after 4 FETCH cycles.
  - Expect imem_req=0 thereafter.
- Error halts:
  - Instruction 0x00000000: fault=1, no retire.
  - `addi x0,x0,9`: x0 stays 0.
  - Taken `beq x0,x0,+2`: fault=3.
- Reset mid-operation:
  - rst pulsed during EXECUTE: next cycle imem_addr=RESET_PC, a0=0, halted=0.
  - rst pulsed while in HALT: same response.

Source files
------------

// File: rtl/multicycle_core_if.sv
// Instruction-memory fetch channel between multicycle_core (master) and the
// memory or harness that answers its requests (slave).
interface multicycle_core_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_valid;
  logic [31:0]           imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I subset core (ADD, SUB, ADDI, BEQ, BNE, EBREAK).
// The FSM sequences FETCH/DECODE/EXECUTE/WRITEBACK and latches halt causes.
module multicycle_core #(
  parameter int unsigned          ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
  parameter int unsigned          FETCH_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_core_if.master   imem,
  output logic [31:0]         a0,
  output logic                retire,
  output logic                halted,
  output logic [1:0]          fault
);

  localparam int unsigned WAIT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_ADDI,
    OP_BEQ,
    OP_BNE,
    OP_EBREAK,
    OP_ILLEGAL
  } op_e;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'd0,
    FAULT_ILLEGAL = 2'd1,
    FAULT_TIMEOUT = 2'd2,
    FAULT_MISALIGN = 2'd3
  } fault_e;

  state_e                state_q, state_d;
  fault_e                fault_q, fault_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [31:0]           instr_q;
  logic [WAIT_W-1:0]     wait_q;
  logic [31:0]           regs [32];
  op_e                   op_q;
  logic [31:0]           rs1_val_q, rs2_val_q, imm_q, result_q;
  logic                  taken_q;
  logic [ADDR_WIDTH-1:0] target_q;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_b, dec_imm;
  op_e         dec_op;

  logic                  exe_eq, exe_taken;
  logic [ADDR_WIDTH-1:0] exe_target;
  logic [31:0]           exe_result;
  logic                  fetch_timeout;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign funct7 = instr_q[31:25];

  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                  instr_q[11:8], 1'b0};

  always_comb begin
    dec_op  = OP_ILLEGAL;
    dec_imm = imm_i;
    if (instr_q == EBREAK_WORD) begin
      dec_op = OP_EBREAK;
    end else begin
      unique case (opcode)
        7'b0110011: begin
          if (funct3 == 3'b000 && funct7 == 7'b0000000) dec_op = OP_ADD;
          else if (funct3 == 3'b000 && funct7 == 7'b0100000) dec_op = OP_SUB;
        end
        7'b0010011: begin
          if (funct3 == 3'b000) dec_op = OP_ADDI;
        end
        7'b1100011: begin
          dec_imm = imm_b;
          if (funct3 == 3'b000) dec_op = OP_BEQ;
          else if (funct3 == 3'b001) dec_op = OP_BNE;
        end
        default: dec_op = OP_ILLEGAL;
      endcase
    end
  end

  assign exe_eq     = (rs1_val_q == rs2_val_q);
  assign exe_taken  = ((op_q == OP_BEQ) && exe_eq) || ((op_q == OP_BNE) && !exe_eq);
  assign exe_target = pc_q + ADDR_WIDTH'(signed'(imm_q));

  always_comb begin
    exe_result = rs1_val_q + rs2_val_q;
    if (op_q == OP_SUB) exe_result = rs1_val_q - rs2_val_q;
    else if (op_q == OP_ADDI) exe_result = rs1_val_q + imm_q;
  end

  // The Nth consecutive empty FETCH cycle sees wait_q == N-1; valid in that cycle still wins.
  assign fetch_timeout = (FETCH_TIMEOUT != 0) &&
                         (wait_q == WAIT_W'(FETCH_TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    fault_d  = fault_q;
    imem.imem_req = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_valid) begin
          state_d = DECODE;
        end else if (fetch_timeout) begin
          state_d = HALT;
          fault_d = FAULT_TIMEOUT;
        end
      end
      DECODE: begin
        if (dec_op == OP_ILLEGAL) begin
          state_d = HALT;
          fault_d = FAULT_ILLEGAL;
        end else if (dec_op == OP_EBREAK) begin
          state_d = HALT;
          fault_d = FAULT_NONE;
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        if (exe_taken && exe_target[1]) begin
          state_d = HALT;
          fault_d = FAULT_MISALIGN;
        end else begin
          state_d = WRITEBACK;
        end
      end
      WRITEBACK: begin
        retire  = 1'b1;
        state_d = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      wait_q    <= '0;
      op_q      <= OP_ILLEGAL;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
      result_q  <= '0;
      taken_q   <= 1'b0;
      target_q  <= '0;
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem.imem_valid) begin
            instr_q <= imem.imem_rdata;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        DECODE: begin
          rs1_val_q <= regs[rs1];
          rs2_val_q <= regs[rs2];
          imm_q     <= dec_imm;
          op_q      <= dec_op;
        end
        EXECUTE: begin
          result_q <= exe_result;
          taken_q  <= exe_taken;
          target_q <= exe_target;
        end
        WRITEBACK: begin
          // x0 is never written, so reads of regs[0] stay zero without a mux.
          if ((op_q == OP_ADD || op_q == OP_SUB || op_q == OP_ADDI) && rd != 5'd0)
            regs[rd] <= result_q;
          pc_q <= taken_q ? target_q : pc_q + ADDR_WIDTH'(4);
        end
        default: ;
      endcase
    end
  end

  assign imem.imem_addr = pc_q;
  assign a0             = regs[10];
  assign fault          = fault_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: one instance with a wait-stated program
// memory (timeout 16) and one with a hand-driven fetch channel (timeout 4).
module tb_multicycle_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_core_if #(.ADDR_WIDTH(32)) bus ();
  multicycle_core_if #(.ADDR_WIDTH(32)) bus4 ();

  logic [31:0] a0, a0_4;
  logic        retire, retire_4, halted, halted_4;
  logic [1:0]  fault, fault_4;

  multicycle_core #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .FETCH_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .imem(bus), .a0(a0), .retire(retire), .halted(halted), .fault(fault)
  );

  multicycle_core #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .FETCH_TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .imem(bus4), .a0(a0_4), .retire(retire_4), .halted(halted_4),
    .fault(fault_4)
  );

  // Program memory: answers mem_wait cycles after the request rises.
  logic [31:0] prog [0:63];
  int unsigned mem_wait = 0;
  int unsigned mem_cnt  = 0;
  always @(posedge clk) begin
    if (rst || !bus.imem_req || bus.imem_valid) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
  end
  assign bus.imem_valid = bus.imem_req && (mem_cnt == mem_wait);
  assign bus.imem_rdata = prog[bus.imem_addr[7:2]];

  logic v4 = 1'b0;
  assign bus4.imem_valid = v4;
  assign bus4.imem_rdata = 32'h0050_0513;

  int n_checks = 0;
  int n_fail   = 0;

  int          ret_cyc[$];
  logic [31:0] ret_pc[$];
  int          halt_cyc;
  logic [31:0] a0_log   [0:255];
  logic [31:0] addr_log [0:255];
  logic        req_log  [0:255];

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0010_0073;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Observes the main core from cycle 1 (first cycle after reset) until halt or budget.
  task automatic run(input int budget);
    ret_cyc.delete();
    ret_pc.delete();
    halt_cyc = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      a0_log[c]   = a0;
      addr_log[c] = bus.imem_addr;
      req_log[c]  = bus.imem_req;
      if (retire) begin
        ret_cyc.push_back(c);
        ret_pc.push_back(bus.imem_addr);
      end
      if (halted) begin
        halt_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_prog();
    mem_wait = 0;
    do_reset();
    @(negedge clk);
    n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_req: got %b expected 1", bus.imem_req); end
    n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", bus.imem_addr); end
    n_checks++; if (a0 !== 32'h0) begin n_fail++; $display("FAIL rst_a0: got %h expected 0", a0); end
    n_checks++; if (retire !== 1'b0) begin n_fail++; $display("FAIL rst_retire: got %b expected 0", retire); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b expected 0", halted); end
    n_checks++; if (fault !== 2'd0) begin n_fail++; $display("FAIL rst_fault: got %0d expected 0", fault); end
  endtask

  task automatic test_zero_wait();
    int r0, r1;
    clear_prog();
    prog[0] = 32'h0050_0513;   // addi x10,x0,5
    prog[1] = 32'hFF95_0513;   // addi x10,x10,-7
    do_reset();
    run(40);
    r0 = (ret_cyc.size() > 0) ? ret_cyc[0] : -1;
    r1 = (ret_cyc.size() > 1) ? ret_cyc[1] : -1;
    n_checks++; if (ret_cyc.size() !== 2) begin n_fail++; $display("FAIL zw_nret: got %0d expected 2", ret_cyc.size()); end
    n_checks++; if (r0 !== 4) begin n_fail++; $display("FAIL zw_ret0: got %0d expected 4", r0); end
    n_checks++; if (r1 !== 8) begin n_fail++; $display("FAIL zw_ret1: got %0d expected 8", r1); end
    n_checks++; if (a0_log[5] !== 32'h5) begin n_fail++; $display("FAIL zw_a0_first: got %h expected 5", a0_log[5]); end
    n_checks++; if (a0_log[9] !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL zw_a0: got %h expected fffffffe", a0_log[9]); end
    n_checks++; if (halt_cyc !== 11) begin n_fail++; $display("FAIL zw_halt_cyc: got %0d expected 11", halt_cyc); end
    n_checks++; if (fault !== 2'd0) begin n_fail++; $display("FAIL zw_fault: got %0d expected 0", fault); end
  endtask

  task automatic test_sub();
    clear_prog();
    prog[0] = 32'h00A0_0093;   // addi x1,x0,10
    prog[1] = 32'h0030_0113;   // addi x2,x0,3
    prog[2] = 32'h4020_8533;   // sub x10,x1,x2
    prog[3] = 32'h4011_0533;   // sub x10,x2,x1
    do_reset();
    run(60);
    n_checks++; if (ret_cyc.size() !== 4) begin n_fail++; $display("FAIL sub_nret: got %0d expected 4", ret_cyc.size()); end
    n_checks++; if (a0_log[13] !== 32'h7) begin n_fail++; $display("FAIL sub_pos: got %h expected 7", a0_log[13]); end
    n_checks++; if (a0_log[17] !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL sub_neg: got %h expected fffffff9", a0_log[17]); end
    n_checks++; if (halt_cyc !== 19) begin n_fail++; $display("FAIL sub_halt_cyc: got %0d expected 19", halt_cyc); end
  endtask

  task automatic test_wait_states();
    int r0, r1;
    logic hold_ok;
    clear_prog();
    prog[0] = 32'h0020_8533;   // add x10,x1,x2
    prog[1] = 32'h0020_8533;
    mem_wait = 3;
    do_reset();
    run(60);
    mem_wait = 0;
    r0 = (ret_cyc.size() > 0) ? ret_cyc[0] : -1;
    r1 = (ret_cyc.size() > 1) ? ret_cyc[1] : -1;
    hold_ok = 1'b1;
    for (int c = 1; c <= 4; c++) if (req_log[c] !== 1'b1 || addr_log[c] !== 32'h0) hold_ok = 1'b0;
    for (int c = 8; c <= 11; c++) if (req_log[c] !== 1'b1 || addr_log[c] !== 32'h4) hold_ok = 1'b0;
    n_checks++; if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL ws_addr_hold: got %b expected 1", hold_ok); end
    n_checks++; if (req_log[5] !== 1'b0) begin n_fail++; $display("FAIL ws_req_fall: got %b expected 0", req_log[5]); end
    n_checks++; if (r0 !== 7) begin n_fail++; $display("FAIL ws_ret0: got %0d expected 7", r0); end
    n_checks++; if (r1 !== 14) begin n_fail++; $display("FAIL ws_ret1: got %0d expected 14", r1); end
    n_checks++; if (halt_cyc !== 20) begin n_fail++; $display("FAIL ws_halt_cyc: got %0d expected 20", halt_cyc); end
    n_checks++; if (fault !== 2'd0) begin n_fail++; $display("FAIL ws_fault: got %0d expected 0", fault); end
  endtask

  task automatic test_loop();
    int nbne;
    logic [31:0] p3;
    clear_prog();
    prog[0] = 32'h0030_0293;   // addi x5,x0,3
    prog[1] = 32'hFFF2_8293;   // addi x5,x5,-1
    prog[2] = 32'hFE02_9EE3;   // bne x5,x0,-4
    prog[3] = 32'h0010_0513;   // addi x10,x0,1
    do_reset();
    run(80);
    nbne = 0;
    foreach (ret_pc[i]) if (ret_pc[i] == 32'h8) nbne++;
    p3 = (ret_pc.size() > 3) ? ret_pc[3] : 32'hDEAD_BEEF;
    n_checks++; if (nbne !== 3) begin n_fail++; $display("FAIL loop_bne: got %0d expected 3", nbne); end
    n_checks++; if (ret_cyc.size() !== 8) begin n_fail++; $display("FAIL loop_nret: got %0d expected 8", ret_cyc.size()); end
    n_checks++; if (p3 !== 32'h4) begin n_fail++; $display("FAIL loop_target: got %h expected 4", p3); end
    n_checks++; if (a0 !== 32'h1) begin n_fail++; $display("FAIL loop_a0: got %h expected 1", a0); end
    n_checks++; if (halt_cyc !== 35) begin n_fail++; $display("FAIL loop_halt_cyc: got %0d expected 35", halt_cyc); end
  endtask

  task automatic test_timeout();
    logic pre_ok;
    v4 = 1'b0;
    do_reset();
    pre_ok = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (halted_4 !== 1'b0 || bus4.imem_req !== 1'b1 || bus4.imem_addr !== 32'h0) pre_ok = 1'b0;
    end
    n_checks++; if (pre_ok !== 1'b1) begin n_fail++; $display("FAIL to_pre: got %b expected 1", pre_ok); end
    @(negedge clk);
    n_checks++; if (halted_4 !== 1'b1) begin n_fail++; $display("FAIL to_halted: got %b expected 1", halted_4); end
    n_checks++; if (fault_4 !== 2'd2) begin n_fail++; $display("FAIL to_fault: got %0d expected 2", fault_4); end
    @(negedge clk);
    n_checks++; if (bus4.imem_req !== 1'b0) begin n_fail++; $display("FAIL to_req: got %b expected 0", bus4.imem_req); end
  endtask

  task automatic test_timeout_boundary();
    v4 = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    @(negedge clk);
    v4 = 1'b1;                 // valid in the 4th empty cycle
    @(negedge clk);
    v4 = 1'b0;
    n_checks++; if (halted_4 !== 1'b0 || fault_4 !== 2'd0) begin n_fail++; $display("FAIL tb_win: got halted=%b fault=%0d expected 0/0", halted_4, fault_4); end
    n_checks++; if (bus4.imem_req !== 1'b0) begin n_fail++; $display("FAIL tb_req: got %b expected 0", bus4.imem_req); end
    repeat (2) @(negedge clk);
    n_checks++; if (retire_4 !== 1'b1) begin n_fail++; $display("FAIL tb_retire: got %b expected 1", retire_4); end
    @(negedge clk);
    n_checks++; if (a0_4 !== 32'h5) begin n_fail++; $display("FAIL tb_a0: got %h expected 5", a0_4); end
  endtask

  task automatic test_errors();
    clear_prog();
    prog[0] = 32'h0000_0000;
    do_reset();
    run(20);
    n_checks++; if (halt_cyc !== 3) begin n_fail++; $display("FAIL ill_halt_cyc: got %0d expected 3", halt_cyc); end
    n_checks++; if (fault !== 2'd1) begin n_fail++; $display("FAIL ill_fault: got %0d expected 1", fault); end
    n_checks++; if (ret_cyc.size() !== 0) begin n_fail++; $display("FAIL ill_nret: got %0d expected 0", ret_cyc.size()); end

    clear_prog();
    prog[0] = 32'h0030_0513;   // addi x10,x0,3
    prog[1] = 32'h0090_0013;   // addi x0,x0,9
    prog[2] = 32'h0000_0533;   // add x10,x0,x0
    do_reset();
    run(40);
    n_checks++; if (a0_log[5] !== 32'h3) begin n_fail++; $display("FAIL x0_pre: got %h expected 3", a0_log[5]); end
    n_checks++; if (a0 !== 32'h0) begin n_fail++; $display("FAIL x0_zero: got %h expected 0", a0); end
    n_checks++; if (ret_cyc.size() !== 3) begin n_fail++; $display("FAIL x0_nret: got %0d expected 3", ret_cyc.size()); end

    clear_prog();
    prog[0] = 32'h0000_0163;   // beq x0,x0,+2
    do_reset();
    run(20);
    n_checks++; if (halt_cyc !== 4) begin n_fail++; $display("FAIL mis_halt_cyc: got %0d expected 4", halt_cyc); end
    n_checks++; if (fault !== 2'd3) begin n_fail++; $display("FAIL mis_fault: got %0d expected 3", fault); end
    n_checks++; if (ret_cyc.size() !== 0) begin n_fail++; $display("FAIL mis_nret: got %0d expected 0", ret_cyc.size()); end

    clear_prog();
    prog[0] = 32'h0000_1163;   // bne x0,x0,+2 (not taken, so no fault)
    do_reset();
    run(20);
    n_checks++; if (halt_cyc !== 7 || fault !== 2'd0) begin n_fail++; $display("FAIL nt_branch: got halt_cyc=%0d fault=%0d expected 7/0", halt_cyc, fault); end
  endtask

  task automatic test_reset_mid();
    clear_prog();
    prog[0] = 32'h0050_0513;
    prog[1] = 32'hFF95_0513;
    do_reset();
    repeat (7) @(negedge clk);
    n_checks++; if (a0 !== 32'h5 || bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL rm_pre: got a0=%h addr=%h expected 5/4", a0, bus.imem_addr); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rm_addr: got addr=%h req=%b expected 0/1", bus.imem_addr, bus.imem_req); end
    n_checks++; if (a0 !== 32'h0) begin n_fail++; $display("FAIL rm_a0: got %h expected 0", a0); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rm_halted: got %b expected 0", halted); end
  endtask

  task automatic test_reset_halt();
    logic frozen;
    clear_prog();
    prog[0] = 32'h0050_0513;
    do_reset();
    run(20);
    n_checks++; if (halt_cyc !== 7) begin n_fail++; $display("FAIL rh_halt_cyc: got %0d expected 7", halt_cyc); end
    frozen = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (a0 !== 32'h5 || bus.imem_req !== 1'b0 || halted !== 1'b1) frozen = 1'b0;
    end
    n_checks++; if (frozen !== 1'b1) begin n_fail++; $display("FAIL rh_frozen: got %b expected 1", frozen); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rh_addr: got addr=%h req=%b expected 0/1", bus.imem_addr, bus.imem_req); end
    n_checks++; if (a0 !== 32'h0) begin n_fail++; $display("FAIL rh_a0: got %h expected 0", a0); end
    n_checks++; if (halted !== 1'b0 || fault !== 2'd0) begin n_fail++; $display("FAIL rh_status: got halted=%b fault=%0d expected 0/0", halted, fault); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_sub();
    test_wait_states();
    test_loop();
    test_timeout();
    test_timeout_boundary();
    test_errors();
    test_reset_mid();
    test_reset_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
